// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 8;

   // Bit-counter width for a given operand width; counter spans 0 .. width-1.
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full-subtractor slice: d = a - b - bin, bout = borrow out.
// Purely combinational; no latency, no flow control.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned A-B, LSB first; done pulses WIDTH cycles after start accept.
// start is only taken in IDLE/DONE; it is ignored while busy.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   diff_sr_q, diff_sr_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               br_q, br_d;
   logic               borrow_q, borrow_d;
   logic               slice_d;
   logic               slice_bout;

   full_sub u_full_sub (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (slice_d),
      .bout (slice_bout)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      diff_sr_d = diff_sr_q;
      diff_d    = diff_q;
      cnt_d     = cnt_q;
      br_d      = br_q;
      borrow_d  = borrow_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_in) begin
               a_d     = a_in;
               b_d     = b_in;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d       = a_q >> 1;
            b_d       = b_q >> 1;
            diff_sr_d = {slice_d, diff_sr_q[WIDTH-1:1]};
            br_d      = slice_bout;
            cnt_d     = cnt_q + CNT_W'(1);
            // Last slice: publish the full result including this cycle's bit.
            if (cnt_q == CNT_LAST) begin
               diff_d   = diff_sr_d;
               borrow_d = slice_bout;
               cnt_d    = '0;
               state_d  = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         diff_sr_q <= '0;
         diff_q    <= '0;
         cnt_q     <= '0;
         br_q      <= 1'b0;
         borrow_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         diff_sr_q <= diff_sr_d;
         diff_q    <= diff_d;
         cnt_q     <= cnt_d;
         br_q      <= br_d;
         borrow_q  <= borrow_d;
      end
   end

   assign busy_out   = (state_q == RUN);
   assign done_out   = (state_q == DONE);
   assign diff_out   = diff_q;
   assign borrow_out = borrow_q;

endmodule
